// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key expansion sequencer with an 11-entry round-key buffer
// Drives an external aes_key_expand_128 and serves captured round keys through a random-access read port.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] key_in_i,
  input  logic         clr_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic         exp_kld_o,
  output logic [127:0] exp_key_o,
  input  logic [127:0] exp_w_i,
  input  logic         rd_en_i,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o,
  output logic         rd_valid_o,
  output logic         rd_err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] key_q;
  logic [127:0] rk_buf_q [0:NUM_ROUNDS];
  logic         busy_q;
  logic         ready_q;
  logic         kld_q;
  logic [127:0] rd_key_q;
  logic         rd_valid_q;
  logic         rd_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      kld_q      <= 1'b0;
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_buf_q[i] <= '0;
    end else begin
      // Reads see the pre-edge ready/buffer, so they are unaffected by a same-cycle start or clr.
      if (rd_en_i) begin
        if (ready_q && (rd_round_i <= LAST)) begin
          rd_key_q   <= rk_buf_q[rd_round_i];
          rd_valid_q <= 1'b1;
          rd_err_q   <= 1'b0;
        end else begin
          rd_key_q   <= '0;
          rd_valid_q <= 1'b0;
          rd_err_q   <= 1'b1;
        end
      end else begin
        rd_valid_q <= 1'b0;
        rd_err_q   <= 1'b0;
      end

      if (clr_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        key_q   <= '0;
        busy_q  <= 1'b0;
        ready_q <= 1'b0;
        kld_q   <= 1'b0;
        for (int i = 0; i <= NUM_ROUNDS; i++) rk_buf_q[i] <= '0;
      end else begin
        case (state_q)
          IDLE, READY: begin
            if (start_i) begin
              key_q   <= key_in_i;
              state_q <= LOAD;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              kld_q   <= 1'b1;
            end
          end
          LOAD: begin
            state_q <= EXPAND;
            cnt_q   <= '0;
            kld_q   <= 1'b0;
          end
          EXPAND: begin
            // The expander advances one round per edge, so exp_w_i is always RK[cnt_q] here.
            rk_buf_q[cnt_q] <= exp_w_i;
            cnt_q           <= cnt_q + 4'd1;
            if (cnt_q == LAST) begin
              state_q <= READY;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign exp_kld_o  = kld_q;
  assign exp_key_o  = key_q;
  assign rd_key_o   = rd_key_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;

endmodule
